// File: rtl/addseq_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
// Contents: nibble width, sequencer state enum, nibble-count helper.
package addseq_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of nibble passes needed for a width-bit operation.
    function automatic int unsigned nib_count(input int unsigned width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/addseq_if.sv
// Operand/result handshake bundle for the add/subtract sequencer.
// master: operand source + result sink side; slave: the sequencer.
//   in_valid/in_ready/in_a/in_b/in_sub   operand request channel
//   out_valid/out_ready/out_sum/out_cout/out_ovf   result channel
interface addseq_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

endinterface

// File: rtl/addseq_ctrl.sv
// Sequencer control: IDLE/RUN/DONE FSM, nibble counter, handshake flags.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid, out_ready   handshake requests from source / sink
//   in_ready, out_valid   registered handshake responses
//   k                     index of the nibble presented this cycle
//   accept_c              operand accepted at the coming edge
//   run_c                 a nibble is being presented this cycle
//   final_c               the presented nibble is the last one
module addseq_ctrl
    import addseq_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] k,
    output logic             accept_c,
    output logic             run_c,
    output logic             final_c
);

    state_t state_q;
    state_t state_nxt;

    // Next-state and per-cycle strobes.
    always_comb begin
        state_nxt = state_q;
        accept_c  = 1'b0;
        run_c     = 1'b0;
        final_c   = 1'b0;
        case (state_q)
            IDLE: begin
                accept_c = in_valid & in_ready;
                if (accept_c) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                run_c = 1'b1;
                if (k == CNT_W'(N - 1)) begin
                    final_c   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_valid & out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Registered handshake flags follow the next state; counter restarts on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            k         <= '0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            if (accept_c || final_c) begin
                k <= '0;
            end else if (run_c) begin
                k <= k + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/addsub_nibble_seq.sv
// Multi-word add/subtract sequencer driving an external 4-bit adder one
// nibble per cycle, LSB nibble first, with a registered carry chain.
// Subtraction is A + ~B + 1: B is inverted at accept and the carry seeded
// with 1, so the adder always runs in add mode.
// Optional feature macro: ADDSEQ_OVF_EN enables the signed-overflow flag;
// without it out_ovf is tied low.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   bus (slave)    operand/result valid-ready channels
//   nib_a, nib_b   adder operand nibbles (nib_b pre-inverted for subtract)
//   nib_c0         adder carry-in
//   nib_select     adder mode, fixed at add
//   nib_sum        adder sum nibble
//   nib_cout       adder carry-out
module addsub_nibble_seq
    import addseq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    addseq_if.slave          bus,
    output logic [NIB_W-1:0] nib_a,
    output logic [NIB_W-1:0] nib_b,
    output logic             nib_c0,
    output logic             nib_select,
    input  logic [NIB_W-1:0] nib_sum,
    input  logic             nib_cout
);

    localparam int unsigned N     = nib_count(WIDTH);
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ACC_W = WIDTH - NIB_W;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [ACC_W-1:0] acc_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [CNT_W-1:0] k;
    logic             accept_c;
    logic             run_c;
    logic             final_c;

    addseq_ctrl #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .in_ready  (bus.in_ready),
        .out_valid (bus.out_valid),
        .k         (k),
        .accept_c  (accept_c),
        .run_c     (run_c),
        .final_c   (final_c)
    );

    // Nibble k of the held operands goes to the adder only while running.
    always_comb begin
        nib_a      = '0;
        nib_b      = '0;
        nib_c0     = 1'b0;
        nib_select = 1'b1;
        if (run_c) begin
            nib_a  = NIB_W'(a_q >> (k * NIB_W));
            nib_b  = NIB_W'(b_q >> (k * NIB_W));
            nib_c0 = carry_q;
        end
    end

    // Operand capture, carry chain and result assembly.
    // Lower nibbles shift into acc_q from the top, so after N-1 captures it
    // holds nibbles 0..N-2 in place and the final nibble completes the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept_c) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b ^ {WIDTH{bus.in_sub}};
            carry_q <= bus.in_sub;
        end else if (run_c) begin
            carry_q <= nib_cout;
            acc_q   <= ACC_W'({nib_sum, acc_q} >> NIB_W);
            if (final_c) begin
                sum_q  <= {nib_sum, acc_q};
                cout_q <= nib_cout;
            end
        end
    end

    assign bus.out_sum  = sum_q;
    assign bus.out_cout = cout_q;

`ifdef ADDSEQ_OVF_EN
    logic ovf_q;

    // Carry into the MSB xor carry out of it, taken at the final capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (final_c) begin
            ovf_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ nib_sum[NIB_W-1] ^ nib_cout;
        end
    end

    assign bus.out_ovf = ovf_q;
`else
    assign bus.out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Bench for addsub_nibble_seq (WIDTH=16) with a 4-bit adder stage modelled
// alongside. A per-cycle compare process checks every output against an
// arithmetic model of the operation; directed cases pin literal results.
module tb_addsub_nibble_seq;

    localparam int unsigned W = 16;
    localparam int unsigned N = 4;
`ifdef ADDSEQ_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    addseq_if #(.WIDTH(W)) bus ();

    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic       nib_c0;
    logic       nib_select;
    logic [3:0] nib_sum;
    logic       nib_cout;
    logic [3:0] nb_inv;
    logic [4:0] add_r;

    // 4-bit adder stage: add when select=1, subtract otherwise.
    assign nb_inv   = ~nib_b;
    assign add_r    = nib_select ? (5'(nib_a) + 5'(nib_b) + 5'(nib_c0))
                                 : (5'(nib_a) + 5'(nb_inv) + 5'(nib_c0));
    assign nib_sum  = add_r[3:0];
    assign nib_cout = add_r[4];

    addsub_nibble_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .nib_a      (nib_a),
        .nib_b      (nib_b),
        .nib_c0     (nib_c0),
        .nib_select (nib_select),
        .nib_sum    (nib_sum),
        .nib_cout   (nib_cout)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s timed out t=%0t", name, $time);
    endtask

    // {ovf, cout, sum} from plain integer arithmetic and sign rules.
    function automatic logic [17:0] ref_out(input logic [15:0] a, input logic [15:0] b, input logic sub);
        int unsigned ua;
        int unsigned ub;
        logic [15:0] s;
        logic        c;
        logic        v;
        ua = 32'(a);
        ub = 32'(b);
        if (sub) begin
            s = 16'(ua - ub);
            c = (ua >= ub);
            v = (a[15] != b[15]) && (s[15] != a[15]);
        end else begin
            s = 16'(ua + ub);
            c = ((ua + ub) > 32'hFFFF);
            v = (a[15] == b[15]) && (s[15] != a[15]);
        end
        return {v & OVF_ON, c, s};
    endfunction

    // Model state: busy with an operation, cycles since accept, first cycle out of reset.
    bit          m_busy  = 1'b0;
    bit          m_fresh = 1'b1;
    int          m_p     = 0;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic        m_sub;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_sum", bus.out_sum, 0);
            chk("rst_out_cout", bus.out_cout, 0);
            chk("rst_out_ovf", bus.out_ovf, 0);
            chk("rst_nib_a", nib_a, 0);
            chk("rst_nib_c0", nib_c0, 0);
            m_busy  = 1'b0;
            m_fresh = 1'b1;
        end else begin
            chk("in_ready", bus.in_ready, 32'(!m_busy && !m_fresh));
            chk("nib_select", nib_select, 1);
            if (m_busy && m_p <= int'(N)) begin
                int unsigned ua;
                int unsigned bp;
                int unsigned sh;
                int unsigned msk;
                ua  = 32'(m_a);
                bp  = 32'(m_sub ? ~m_b : m_b);
                sh  = 32'(4 * (m_p - 1));
                msk = (32'd1 << sh) - 32'd1;
                chk("out_valid_run", bus.out_valid, 0);
                chk("nib_a", nib_a, (ua >> sh) & 32'hF);
                chk("nib_b", nib_b, (bp >> sh) & 32'hF);
                chk("nib_c0", nib_c0, (((ua & msk) + (bp & msk) + 32'(m_sub)) >> sh) & 32'd1);
            end else begin
                chk("out_valid", bus.out_valid, 32'(m_busy));
                chk("nib_a_idle", nib_a, 0);
                chk("nib_b_idle", nib_b, 0);
                chk("nib_c0_idle", nib_c0, 0);
                if (m_busy) begin
                    logic [17:0] r;
                    r = ref_out(m_a, m_b, m_sub);
                    chk("out_sum", bus.out_sum, 32'(r[15:0]));
                    chk("out_cout", bus.out_cout, 32'(r[16]));
                    chk("out_ovf", bus.out_ovf, 32'(r[17]));
                end
            end
            // Advance the model across the coming edge.
            if (m_fresh) begin
                m_fresh = 1'b0;
            end else if (!m_busy) begin
                if (bus.in_valid) begin
                    m_busy = 1'b1;
                    m_p    = 1;
                    m_a    = bus.in_a;
                    m_b    = bus.in_b;
                    m_sub  = bus.in_sub;
                end
            end else if (m_p <= int'(N)) begin
                m_p++;
            end else if (bus.out_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic sub);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) timeout("accept");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
        bus.in_sub   = 1'($urandom);
    endtask

    // Returns the number of edges after accept until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 20) timeout("out_valid");
    endtask

    task automatic finish_op(input int stall);
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic sub, input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        start_op(a, b, sub);
        wait_result(lat);
        chk({name, "_latency"}, lat, 4);
        chk({name, "_sum"}, bus.out_sum, 32'(es));
        chk({name, "_cout"}, bus.out_cout, 32'(ec));
        chk({name, "_ovf"}, bus.out_ovf, 32'(eo));
        finish_op(1);
    endtask

    initial begin
        int lat;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed("add_5555", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, OVF_ON);

        // Borrow case: carry-in seeded to 1 on nibble 0.
        start_op(16'h0000, 16'h0001, 1'b1);
        chk("borrow_nib0_c0", nib_c0, 1);
        chk("borrow_nib0_b", nib_b, 32'hE);
        wait_result(lat);
        chk("borrow_sum", bus.out_sum, 32'hFFFF);
        chk("borrow_cout", bus.out_cout, 0);
        finish_op(0);

        // Stall in DONE with a competing request held by the source.
        start_op(16'h00F0, 16'h0010, 1'b0);
        wait_result(lat);
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h0100;
        bus.in_b     = 16'h0200;
        bus.in_sub   = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_sum", bus.out_sum, 32'h0100);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("post_hs_in_ready", bus.in_ready, 1);
        chk("post_hs_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_result(lat);
        chk("queued_latency", lat, 4);
        chk("queued_sum", bus.out_sum, 32'h0300);
        finish_op(0);

        // Reset while nibble 2 is on the adder.
        start_op(16'h7777, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_rst_nib_a", nib_a, 32'h7);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_nib_a", nib_a, 0);
        chk("abort_nib_c0", nib_c0, 0);
        chk("abort_sum", bus.out_sum, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        directed("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Randomized operations with corner operands and sink stalls.
        for (int i = 0; i < 150; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'hFFFF;
            if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h0001;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            bus.out_ready = 1'($urandom);
            start_op(ra, rb, 1'($urandom));
            bus.out_ready = 1'b0;
            wait_result(lat);
            finish_op(int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
